unary_add_sched: RTL and testbench

Round-robin scheduler that shares one 14-bit unary add/accumulate unit between `NREQ` requesters. For each granted job it:
- clears the unit;
- forwards the requester's serial A/B pulse streams for a programmed number of cycles;
- switches the unit to read mode and deserialises the LSB-first count from `dout`;
- returns the result with overflow flag and requester id over a valid/ready port.

It sits between the pulse-generating front ends and the single shared unary adder instance.

---
 rtl/unary_add_sched.sv | 136 +++++++++++++
 tb/tb_unary_add_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/unary_add_sched.sv
// Round-robin scheduler sharing one unary add/accumulate unit across NREQ requesters.
// Build option: define UNARY_SCHED_SAT_EN to saturate res_data to 2^W-1 on overflow.
module unary_add_sched #(
    parameter int NREQ  = 4,
    parameter int W     = 14,
    parameter int LEN_W = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ-1:0]       req_a,
    input  logic [NREQ-1:0]       req_b,
    output logic [NREQ-1:0]       gnt,
    output logic                  add_rst_n,
    output logic                  add_en,
    output logic                  add_rw,
    output logic                  add_a,
    output logic                  add_b,
    input  logic                  add_dout,
    input  logic                  add_c,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [W-1:0]          res_data,
    output logic                  res_ovf,
    output logic [IDW-1:0]        res_id
);
    localparam int RDW = $clog2(W + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, READ, RESP} state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   last_id, id, pick;
    logic             pick_vld;
    logic [LEN_W-1:0] len_q, cnt;
    logic [RDW-1:0]   rd_cnt;
    logic [W-1:0]     sh, sh_nxt, res_nxt;
    logic             ovf;

    // First requesting index after last_id, wrapping around.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!pick_vld && req_valid[(int'(last_id) + k) % NREQ]) begin
                pick     = IDW'((int'(last_id) + k) % NREQ);
                pick_vld = 1'b1;
            end
        end
    end

    assign sh_nxt = {add_dout, sh[W-1:1]};

`ifdef UNARY_SCHED_SAT_EN
    assign res_nxt = ovf ? '1 : sh_nxt;
`else
    assign res_nxt = sh_nxt;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = CLEAR;
            CLEAR:   state_nxt = (len_q == '0) ? DRAIN : ACCUM;
            ACCUM:   if (cnt == LEN_W'(1)) state_nxt = DRAIN;
            DRAIN:   state_nxt = READ;
            READ:    if (rd_cnt == RDW'(W)) state_nxt = RESP;
            RESP:    if (res_valid && res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_id   <= IDW'(NREQ - 1);
            id        <= '0;
            len_q     <= '0;
            cnt       <= '0;
            rd_cnt    <= '0;
            sh        <= '0;
            ovf       <= 1'b0;
            gnt       <= '0;
            add_rst_n <= 1'b0;
            add_en    <= 1'b0;
            add_rw    <= 1'b0;
            add_a     <= 1'b0;
            add_b     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_ovf   <= 1'b0;
            res_id    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (pick_vld) begin
                    id    <= pick;
                    len_q <= req_len[int'(pick)*LEN_W +: LEN_W];
                end
                CLEAR: begin
                    ovf    <= 1'b0;
                    sh     <= '0;
                    cnt    <= len_q;
                    rd_cnt <= '0;
                end
                ACCUM: begin
                    ovf <= ovf | add_c;
                    cnt <= cnt - LEN_W'(1);
                end
                // Carry from the final ACCUM add only becomes visible here.
                DRAIN: ovf <= ovf | add_c;
                READ: begin
                    rd_cnt <= rd_cnt + RDW'(1);
                    if (rd_cnt != '0) sh <= sh_nxt;
                end
                RESP: if (res_valid && res_ready) last_id <= id;
                default: ;
            endcase

            // Outputs are decoded from the next state so they align with it.
            gnt       <= (state_nxt == ACCUM) ? (NREQ'(1) << id) : '0;
            add_rst_n <= (state_nxt != CLEAR);
            add_en    <= (state_nxt == ACCUM) || (state_nxt == READ);
            add_rw    <= (state_nxt == READ);
            add_a     <= (state_nxt == ACCUM) && req_a[id];
            add_b     <= (state_nxt == ACCUM) && req_b[id];
            res_valid <= (state_nxt == RESP);
            if (state == READ && state_nxt == RESP) begin
                res_data <= res_nxt;
                res_ovf  <= ovf;
                res_id   <= id;
            end
        end
    end
endmodule

// File: tb/tb_unary_add_sched.sv
// Directed bench for unary_add_sched with a behavioural model of the shared unary adder.
module tb_unary_add_sched;
    localparam int NREQ  = 4;
    localparam int W     = 14;
    localparam int LEN_W = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*LEN_W-1:0] req_len = '0;
    logic [NREQ-1:0]       req_a = '0;
    logic [NREQ-1:0]       req_b = '0;
    logic [NREQ-1:0]       gnt;
    logic                  add_rst_n, add_en, add_rw, add_a, add_b;
    logic                  add_dout, add_c;
    logic                  res_valid;
    logic                  res_ready = 1'b1;
    logic [W-1:0]          res_data;
    logic                  res_ovf;
    logic [1:0]            res_id;

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    unary_add_sched #(.NREQ(NREQ), .W(W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_len(req_len),
        .req_a(req_a), .req_b(req_b), .gnt(gnt), .add_rst_n(add_rst_n),
        .add_en(add_en), .add_rw(add_rw), .add_a(add_a), .add_b(add_b),
        .add_dout(add_dout), .add_c(add_c), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf), .res_id(res_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Shared adder model: accumulate pulses, registered carry, serial read with 1-cycle latency.
    logic [W-1:0] acc;
    logic [3:0]   rd_ptr;
    always @(posedge clk) begin
        if (!add_rst_n) begin
            acc <= '0; add_c <= 1'b0; add_dout <= 1'b0; rd_ptr <= '0;
        end else if (add_en && !add_rw) begin
            {add_c, acc} <= {1'b0, acc} + (W+1)'(add_a) + (W+1)'(add_b);
            rd_ptr <= '0;
        end else if (add_en && add_rw) begin
            add_c <= 1'b0;
            if (rd_ptr < 4'(W)) add_dout <= acc[rd_ptr];
            rd_ptr <= rd_ptr + 4'd1;
        end else begin
            add_c <= 1'b0; rd_ptr <= '0;
        end
    end

    int gnt_cycles = 0;
    int acc_cycles = 0;
    int onehot_bad = 0;
    int order[$];
    logic [NREQ-1:0] prev_gnt = '0;
    always @(negedge clk) begin
        if (gnt != '0) gnt_cycles++;
        if (add_en && !add_rw) acc_cycles++;
        if ($countones(gnt) > 1) onehot_bad++;
        if (gnt != '0 && prev_gnt == '0)
            for (int i = 0; i < NREQ; i++) if (gnt[i]) order.push_back(i);
        prev_gnt = gnt;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Stream element j is presented during cycle t0+1+j; returns cycles until res_valid.
    task automatic run_job(input int r, input int len, input logic [15:0] pa,
                           input logic [15:0] pb, output int lat);
        int t0;
        req_len[r*LEN_W +: LEN_W] = 16'(len);
        req_valid[r] = 1'b1;
        t0 = cyc;
        gnt_cycles = 0;
        acc_cycles = 0;
        @(negedge clk);
        req_valid[r] = 1'b0;
        for (int j = 0; j < len; j++) begin
            req_a[r] = pa[j % 16];
            req_b[r] = pb[j % 16];
            @(negedge clk);
        end
        req_a[r] = 1'b0;
        req_b[r] = 1'b0;
        while (!res_valid && (cyc - t0) < 9000) @(negedge clk);
        lat = cyc - t0;
        if (!res_valid) check("res_valid_timeout", 32'(res_valid), 32'd1);
    endtask

    initial begin
        int lat, n;
        logic [31:0] hold;

        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_add_rst_n", 32'(add_rst_n), 32'd0);
        check("rst_add_ctl", 32'({add_en, add_rw, add_a, add_b}), 32'd0);
        check("rst_res", 32'({res_valid, res_ovf, res_id}), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_add_rst_n", 32'(add_rst_n), 32'd1);

        // Pulse counting: 3 a-pulses + 4 b-pulses
        run_job(0, 6, 16'b010101, 16'b001111, lat);
        check("cnt_latency", 32'(lat), 32'd24);
        check("cnt_gnt_cycles", 32'(gnt_cycles), 32'd6);
        check("cnt_data", 32'(res_data), 32'd7);
        check("cnt_ovf_id", 32'({res_ovf, res_id}), 32'd0);
        @(negedge clk);
        check("cnt_released", 32'(res_valid), 32'd0);

        // Zero length: round robin moves on to requester 1
        run_job(1, 0, 16'hFFFF, 16'hFFFF, lat);
        check("zero_latency", 32'(lat), 32'd18);
        check("zero_no_gnt", 32'(gnt_cycles), 32'd0);
        check("zero_no_accum", 32'(acc_cycles), 32'd0);
        check("zero_data", 32'(res_data), 32'd0);
        check("zero_id", 32'(res_id), 32'd1);
        @(negedge clk);

        // Overflow: 16384 pulses wrap a 14-bit count
        run_job(2, 8192, 16'hFFFF, 16'hFFFF, lat);
        check("ovf_latency", 32'(lat), 32'd8210);
`ifdef UNARY_SCHED_SAT_EN
        check("ovf_data", 32'(res_data), 32'd16383);
`else
        check("ovf_data", 32'(res_data), 32'd0);
`endif
        check("ovf_flag", 32'(res_ovf), 32'd1);
        check("ovf_id", 32'(res_id), 32'd2);
        @(negedge clk);

        // Fairness from a fresh reset
        do_reset();
        order.delete();
        onehot_bad = 0;
        for (int i = 0; i < NREQ; i++) req_len[i*LEN_W +: LEN_W] = 16'd2;
        req_valid = 4'hF;
        n = 0;
        while (order.size() < 5 && n < 500) begin @(negedge clk); n++; end
        req_valid = '0;
        n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        check("rr_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check("rr_order", 32'(order[i]), 32'(i % NREQ));
        check("rr_onehot", 32'(onehot_bad), 32'd0);

        // Back-pressure with requester 2 pending
        res_ready = 1'b0;
        req_len[2*LEN_W +: LEN_W] = 16'd2;
        req_valid[2] = 1'b1;
        run_job(1, 3, 16'h0007, 16'h0000, lat);
        check("bp_data", 32'(res_data), 32'd3);
        check("bp_id", 32'(res_id), 32'd1);
        hold = 32'({res_valid, res_ovf, res_id, res_data});
        repeat (10) begin
            @(negedge clk);
            check("bp_hold", 32'({res_valid, res_ovf, res_id, res_data}), hold);
            check("bp_no_gnt", 32'(gnt), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_released", 32'({res_valid, add_rst_n}), 32'b01);
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("bp_clear", 32'(add_rst_n), 32'd0);
        @(negedge clk);
        check("bp_gnt2", 32'(gnt), 32'b0100);
        n = 0;
        while (!res_valid && n < 100) begin @(negedge clk); n++; end
        check("bp_job2_id", 32'(res_id), 32'd2);
        check("bp_job2_data", 32'(res_data), 32'd0);
        @(negedge clk);

        // Reset on ACCUM cycle 3
        req_len[3*LEN_W +: LEN_W] = 16'd10;
        req_valid[3] = 1'b1;
        req_a[3] = 1'b1;
        @(negedge clk);
        req_valid[3] = 1'b0;
        repeat (3) @(negedge clk);
        check("rm_in_accum", 32'(gnt), 32'b1000);
        rst = 1'b1;
        @(negedge clk);
        check("rm_gnt", 32'(gnt), 32'd0);
        check("rm_add", 32'({add_rst_n, add_en, add_rw, add_a, add_b}), 32'd0);
        check("rm_res", 32'({res_valid, res_ovf}), 32'd0);
        rst = 1'b0;
        req_a[3] = 1'b0;
        n = 0;
        repeat (30) begin @(negedge clk); if (res_valid) n++; end
        check("rm_no_result", 32'(n), 32'd0);
        // Requesters 1 and 3 both pending: restart from 0 picks 1
        req_valid[3] = 1'b1;
        run_job(1, 5, 16'b01101, 16'b10000, lat);
        req_valid[3] = 1'b0;
        check("rm_next_id", 32'(res_id), 32'd1);
        check("rm_next_data", 32'(res_data), 32'd4);
        check("rm_next_ovf", 32'(res_ovf), 32'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
